// File: rtl/lfsr.sv
// Fibonacci (external-XOR) maximal-length LFSR, WIDTH 2..32, shifting left.
// An all-zero state is replaced by the seed on the next clock so the register cannot lock up.
module lfsr #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] lfsr_o
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("lfsr: WIDTH must be in the range 2..32");
    end

    // Tap masks from the XAPP052 table: tap n sets mask bit n-1.
    function automatic logic [31:0] tap_mask(input int w);
        logic [31:0] m;
        m = '0;
        case (w)
            2:       m = 32'h0000_0003;
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [31:0]      TAPS     = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb;

    always_comb begin
        fb      = ^(state_q & TAPS[WIDTH-1:0]);
        state_d = {state_q[WIDTH-2:0], fb};
        if (state_q == '0) begin
            state_d = SEED_EFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign lfsr_o = state_q;

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: 4-bit sequence, async reset, lockup recovery,
// zero-seed substitution, 8-bit full period and a few 32-bit steps.
module tb_lfsr;

    logic        clk;
    logic        reset;
    logic [3:0]  q4;
    logic [3:0]  q4s0;
    logic [7:0]  q8;
    logic [31:0] q32;

    int n_tests;
    int n_fail;

    lfsr u_dut4 (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (q4)
    );

    lfsr #(.WIDTH(4), .SEED(4'h0)) u_dut_s0 (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (q4s0)
    );

    lfsr #(.WIDTH(8), .SEED(8'h01)) u_dut8 (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (q8)
    );

    lfsr #(.WIDTH(32)) u_dut32 (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (q32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0]  seq4 [15];
    logic [31:0] seq32 [4];
    logic        seen [256];
    int          dup_cnt;
    int          zero_cnt;
    int          distinct;

    initial begin
        seq4 = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        seq32 = '{32'h3, 32'h6, 32'hD, 32'h1B};
        n_tests = 0;
        n_fail  = 0;

        // Reset with no clock edge yet
        reset = 1'b1;
        #1;
        check_eq("rst_async", 32'(q4), 32'h1);
        check_eq("rst_seed0", 32'(q4s0), 32'h1);
        check_eq("rst_w8", 32'(q8), 32'h01);
        check_eq("rst_w32", q32, 32'h1);

        @(posedge clk);
        #1;
        check_eq("rst_hold", 32'(q4), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rel_no_step", 32'(q4), 32'h1);

        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("seq4_%0d", i + 1), 32'(q4), 32'(seq4[(i + 1) % 15]));
            check_eq($sformatf("seq4_s0_%0d", i + 1), 32'(q4s0), 32'(seq4[(i + 1) % 15]));
        end

        // index 2 now; advance to 4'hB (index 9)
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
        end
        #1;
        check_eq("pre_mid_rst", 32'(q4), 32'hB);
        #3;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_async", 32'(q4), 32'h1);
        @(posedge clk);
        #1;
        check_eq("mid_rst_hold", 32'(q4), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_next", 32'(q4), 32'h2);

        // Lockup recovery
        #2;
        force u_dut4.state_q = 4'h0;
        #1;
        release u_dut4.state_q;
        #1;
        check_eq("lock_forced", 32'(q4), 32'h0);
        @(posedge clk);
        #1;
        check_eq("lock_recover", 32'(q4), 32'h1);
        @(posedge clk);
        #1;
        check_eq("lock_next", 32'(q4), 32'h2);

        // Fresh start for the wide instances
        #2;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("w8_start", 32'(q8), 32'h01);

        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1]  = 1'b1;
        distinct = 1;
        dup_cnt  = 0;
        zero_cnt = 0;
        for (int i = 1; i <= 255; i++) begin
            @(posedge clk);
            #1;
            if (i <= 4) begin
                check_eq($sformatf("w32_step%0d", i), q32, seq32[i - 1]);
            end
            if (i < 255) begin
                if (q8 == 8'h00) zero_cnt++;
                else if (seen[q8]) dup_cnt++;
                else begin
                    seen[q8] = 1'b1;
                    distinct++;
                end
            end else begin
                check_eq("w8_wrap", 32'(q8), 32'h01);
            end
        end
        check_eq("w8_dups", 32'(dup_cnt), 32'd0);
        check_eq("w8_zero", 32'(zero_cnt), 32'd0);
        check_eq("w8_distinct", 32'(distinct), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
